// File: rtl/reduction_accumulator_if.sv
// Handshake bundle for reduction_accumulator: frame start, term stream in, result out.
interface reduction_accumulator_if #(
   parameter int unsigned CNT_W = 5
);
   localparam int unsigned DATA_W = 16;

   logic              start;
   logic [CNT_W-1:0]  count;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] red_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] acc_out;
   logic              overflow;
   logic              busy;

   modport master (
      output start, count, in_valid, red_in, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

   modport slave (
      input  start, count, in_valid, red_in, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );
endinterface

// File: rtl/reduction_accumulator.sv
// Frame accumulator: sums `count` signed 16-bit terms, then holds the sum until taken.
// Optional build macro REDUCTION_ACC_SATURATE_EN clamps overflowing adds instead of wrapping.
module reduction_accumulator #(
   parameter int unsigned CNT_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   reduction_accumulator_if.slave bus
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned SUM_W  = DATA_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] acc, acc_nx;
   logic [CNT_W-1:0]  remaining, remaining_nx;
   logic              ovf, ovf_nx;
   logic              in_ready_q, out_valid_q, busy_q;

   logic [SUM_W-1:0]  sum_c;
   logic              add_ovf_c;

   // One extra bit exposes signed overflow: the two top bits disagree.
   always_comb begin
      sum_c     = {acc[DATA_W-1], acc} + {bus.red_in[DATA_W-1], bus.red_in};
      add_ovf_c = sum_c[SUM_W-1] ^ sum_c[DATA_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         remaining   <= '0;
         ovf         <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         acc         <= acc_nx;
         remaining   <= remaining_nx;
         ovf         <= ovf_nx;
         in_ready_q  <= (state_nx == ACCUM);
         out_valid_q <= (state_nx == DONE);
         busy_q      <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      remaining_nx = remaining;
      ovf_nx       = ovf;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               acc_nx       = '0;
               ovf_nx       = 1'b0;
               remaining_nx = bus.count;
               state_nx     = (bus.count != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (bus.in_valid && in_ready_q) begin
`ifdef REDUCTION_ACC_SATURATE_EN
               if (add_ovf_c)
                  acc_nx = sum_c[SUM_W-1] ? DATA_W'(16'h8000) : DATA_W'(16'h7FFF);
               else
                  acc_nx = sum_c[DATA_W-1:0];
`else
               acc_nx = sum_c[DATA_W-1:0];
`endif
               ovf_nx       = ovf | add_ovf_c;
               remaining_nx = remaining - CNT_W'(1);
               if (remaining == CNT_W'(1))
                  state_nx = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.acc_out   = acc;
   assign bus.overflow  = ovf;
endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed bench for reduction_accumulator; outputs sampled on the falling clock edge.
module tb_reduction_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   reduction_accumulator_if #(.CNT_W(5)) bus ();

   reduction_accumulator #(.CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef REDUCTION_ACC_SATURATE_EN
   localparam logic [15:0] POS_OVF_RESULT = 16'h7FFF;
   localparam logic [15:0] NEG_OVF_RESULT = 16'h8000;
`else
   localparam logic [15:0] POS_OVF_RESULT = 16'h8000;
   localparam logic [15:0] NEG_OVF_RESULT = 16'h7FFF;
`endif

   task automatic start_frame(input logic [4:0] n);
      bus.start = 1'b1;
      bus.count = n;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic push(input logic [15:0] v);
      bus.in_valid = 1'b1;
      bus.red_in   = v;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic take_result;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.count = '0; bus.in_valid = 1'b0;
      bus.red_in = '0;  bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.acc_out} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=00000",
                  {bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.acc_out});
      end
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.red_in   = 16'h1111;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.acc_out !== 16'h0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignores_term acc=%h in_ready=%b want acc=0000 in_ready=0",
                  bus.acc_out, bus.in_ready);
      end
   endtask

   task automatic test_basic;
      start_frame(5'd3);
      checks++;
      if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b110 || bus.acc_out !== 16'h0) begin
         failures++;
         $display("FAIL basic_enter_accum flags=%b acc=%h want flags=110 acc=0000",
                  {bus.in_ready, bus.busy, bus.out_valid}, bus.acc_out);
      end
      push(16'h0005);
      push(16'h0003);
      checks++;
      if (bus.acc_out !== 16'h0008 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_partial acc=%h out_valid=%b want acc=0008 out_valid=0",
                  bus.acc_out, bus.out_valid);
      end
      push(16'hFFFE);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc_out !== 16'h0006 ||
          bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL basic_result out_valid=%b in_ready=%b acc=%h ovf=%b want 1 0 0006 0",
                  bus.out_valid, bus.in_ready, bus.acc_out, bus.overflow);
      end
      take_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_handshake out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_zero_count;
      logic saw_ready = 1'b0;
      start_frame(5'd0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.acc_out !== 16'h0) begin
         failures++;
         $display("FAIL zero_done out_valid=%b busy=%b acc=%h want 1 1 0000",
                  bus.out_valid, bus.busy, bus.acc_out);
      end
      for (int i = 0; i < 3; i++) begin
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) saw_ready = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_ready !== 1'b0) begin
         failures++;
         $display("FAIL zero_hold in_ready or out_valid wrong while waiting got=1 want=0");
      end
      take_result();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_handshake out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_overflow;
      start_frame(5'd2);
      push(16'h7FFF);
      checks++;
      if (bus.overflow !== 1'b0 || bus.acc_out !== 16'h7FFF) begin
         failures++;
         $display("FAIL ovf_first acc=%h ovf=%b want 7fff 0", bus.acc_out, bus.overflow);
      end
      push(16'h0001);
      checks++;
      if (bus.overflow !== 1'b1 || bus.acc_out !== POS_OVF_RESULT || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL ovf_positive acc=%h ovf=%b valid=%b want %h 1 1",
                  bus.acc_out, bus.overflow, bus.out_valid, POS_OVF_RESULT);
      end
      take_result();
      start_frame(5'd2);
      checks++;
      if (bus.overflow !== 1'b0 || bus.acc_out !== 16'h0) begin
         failures++;
         $display("FAIL ovf_cleared_on_start acc=%h ovf=%b want 0000 0", bus.acc_out, bus.overflow);
      end
      push(16'h8000);
      push(16'hFFFF);
      checks++;
      if (bus.overflow !== 1'b1 || bus.acc_out !== NEG_OVF_RESULT) begin
         failures++;
         $display("FAIL ovf_negative acc=%h ovf=%b want %h 1",
                  bus.acc_out, bus.overflow, NEG_OVF_RESULT);
      end
      take_result();
      // Third add does not overflow; the flag must stay set from the second.
      start_frame(5'd3);
      push(16'h7FFF);
      push(16'h0001);
      push(16'h0000);
      checks++;
      if (bus.overflow !== 1'b1 || bus.acc_out !== POS_OVF_RESULT) begin
         failures++;
         $display("FAIL ovf_sticky acc=%h ovf=%b want %h 1",
                  bus.acc_out, bus.overflow, POS_OVF_RESULT);
      end
      take_result();
   endtask

   task automatic test_stall;
      logic unstable = 1'b0;
      start_frame(5'd4);
      push(16'h0001);
      bus.red_in = 16'h7777;
      bus.start  = 1'b1;
      bus.count  = 5'd0;
      repeat (2) @(negedge clk);
      bus.start  = 1'b0;
      checks++;
      if (bus.acc_out !== 16'h0001 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_hold acc=%h in_ready=%b valid=%b want 0001 1 0",
                  bus.acc_out, bus.in_ready, bus.out_valid);
      end
      push(16'h0002);
      @(negedge clk);
      push(16'h0003);
      repeat (3) @(negedge clk);
      push(16'h0004);
      checks++;
      if (bus.acc_out !== 16'h000A || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_sum acc=%h valid=%b want 000a 1", bus.acc_out, bus.out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         bus.start = (i % 2 == 0);
         bus.count = 5'd1;
         @(negedge clk);
         if (bus.acc_out !== 16'h000A || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            unstable = 1'b1;
      end
      bus.start = 1'b0;
      checks++;
      if (unstable !== 1'b0) begin
         failures++;
         $display("FAIL done_stable_with_start got_unstable=%b want 0", unstable);
      end
      take_result();
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_handshake busy=%b valid=%b want 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_rst_midframe;
      start_frame(5'd4);
      push(16'h0100);
      push(16'h0200);
      checks++;
      if (bus.acc_out !== 16'h0300) begin
         failures++;
         $display("FAIL rst_pre_sum acc=%h want 0300", bus.acc_out);
      end
      bus.in_valid = 1'b1;
      bus.red_in   = 16'h1234;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.acc_out} !== 20'h0) begin
         failures++;
         $display("FAIL rst_async got=%h want=00000",
                  {bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.acc_out});
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.acc_out !== 16'h0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_discard acc=%h busy=%b want 0000 0", bus.acc_out, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      start_frame(5'd1);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_restart in_ready=%b want 1", bus.in_ready);
      end
      push(16'h0010);
      checks++;
      if (bus.acc_out !== 16'h0010 || bus.out_valid !== 1'b1 || bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL rst_new_frame acc=%h valid=%b ovf=%b want 0010 1 0",
                  bus.acc_out, bus.out_valid, bus.overflow);
      end
      take_result();
   endtask

   task automatic test_back_to_back;
      start_frame(5'd2);
      push(16'h0010);
      push(16'hFFF0);
      checks++;
      if (bus.acc_out !== 16'h0000 || bus.out_valid !== 1'b1 || bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first acc=%h valid=%b ovf=%b want 0000 1 0",
                  bus.acc_out, bus.out_valid, bus.overflow);
      end
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      bus.count     = 5'd1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_start_in_done busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready);
      end
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.acc_out !== 16'h0) begin
         failures++;
         $display("FAIL b2b_second_start in_ready=%b acc=%h want 1 0000", bus.in_ready, bus.acc_out);
      end
      push(16'h1234);
      checks++;
      if (bus.acc_out !== 16'h1234 || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second acc=%h valid=%b want 1234 1", bus.acc_out, bus.out_valid);
      end
      take_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_overflow();
      test_stall();
      test_rst_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reduction_accumulator.md
REDUCTION_ACCUMULATOR -- requirements
Module: reduction_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 5, width of term-count input and internal remaining-term counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, begin new accumulation frame (sampled in IDLE only).
REQ-005 SHALL have port count, input, CNT_W, number of terms in frame, sampled with start.
REQ-006 SHALL have port in_valid, input, 1, red_in holds a valid term.
REQ-007 SHALL have port in_ready, output, 1, block accepts a term this cycle.
REQ-008 SHALL have port red_in, input, 16, signed two's-complement term from the upstream reduction stage.
REQ-009 SHALL have port out_valid, output, 1, acc_out holds the final frame sum.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port acc_out, output, 16, signed frame sum.
REQ-012 SHALL have port overflow, output, 1, sticky per-frame signed-overflow flag.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, ACCUM, DONE.
REQ-015 In IDLE, start=1 and count!=0 SHALL clear accumulator and overflow, load remaining=count, enter ACCUM next cycle.
REQ-016 In IDLE, start=1 and count=0 SHALL clear accumulator and overflow and enter DONE directly (acc_out=0x0000).
REQ-017 start SHALL be ignored in ACCUM and DONE; no frame restart without passing through IDLE.
REQ-018 in_ready SHALL be 1 exactly when state is ACCUM; 0 in IDLE and DONE.
REQ-019 A term SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; one term per cycle maximum.
REQ-020 On acceptance, accumulator SHALL update to accumulator+red_in (16-bit signed) and remaining SHALL decrement by 1.
REQ-021 Acceptance with remaining=1 SHALL transition to DONE on the same edge; final term included in acc_out.
REQ-022 in_valid=0 in ACCUM SHALL hold accumulator and remaining unchanged (unbounded stall).
REQ-023 overflow SHALL set on any accepted add whose true signed result is outside -32768..32767, and stay set until next frame start or reset.
REQ-024 In DONE, out_valid SHALL be 1 and acc_out/overflow SHALL be stable until handshake.
REQ-025 out_valid=1 and out_ready=1 SHALL return FSM to IDLE next cycle; out_valid low thereafter.
REQ-026 acc_out SHALL reflect accumulator register in all states (registered, no combinational path from red_in).
REQ-027 Latency: result SHALL be valid the cycle after final term acceptance; throughput one term per cycle.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE, accumulator 0x0000, remaining 0, overflow 0, out_valid 0, in_ready 0, busy 0.
REQ-029 rst asserted mid-frame (ACCUM or DONE) SHALL abandon the frame with no result; a term presented that cycle SHALL be discarded.
REQ-030 After rst deasserts, first rising edge SHALL see IDLE and honour start.

Configuration
REQ-031 Macro REDUCTION_ACC_SATURATE_EN defined SHALL clamp each overflowing add to 0x7FFF (positive) or 0x8000 (negative).
REQ-032 Macro REDUCTION_ACC_SATURATE_EN undefined SHALL wrap modulo 2^16; overflow flag behaviour identical in both builds.

Verification
REQ-033 start, count=3; terms 0x0005,0x0003,0xFFFE back-to-back -> out_valid one cycle after third term, acc_out=0x0006, overflow=0.
REQ-034 start, count=0 -> DONE without in_ready ever high; acc_out=0x0000, out_valid until out_ready.
REQ-035 count=2; terms 0x7FFF,0x0001 -> overflow=1; acc_out=0x8000 wrap build, 0x7FFF saturate build.
REQ-036 count=4 with in_valid gaps and out_ready held 0 for 5 cycles in DONE -> sum correct, acc_out stable, start pulses during DONE ignored.
REQ-037 rst pulsed after 2 of 4 terms -> all outputs zero immediately; new frame count=1 term 0x0010 -> acc_out=0x0010.
